// File: rtl/sha_nonce_dispatcher.sv
// sha_nonce_dispatcher: accepts work (work_*), streams nonces to the SHA pipeline (pipe_*), matches in-order results and reports leading-zero hits (found_*), with busy/done/lost_count status
module sha_nonce_dispatcher #(
  parameter int LATENCY = 65,
  parameter int LOST_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              work_valid,
  output logic              work_ready,
  input  logic [255:0]      work_digest_initial,
  input  logic [255:0]      work_digest_in,
  input  logic [95:0]       work_block,
  input  logic [31:0]       work_nonce_start,
  input  logic [31:0]       work_nonce_end,
  input  logic [7:0]        work_zero_bits,
  input  logic              abort,
  output logic              pipe_write_en,
  output logic [255:0]      pipe_digest_initial,
  output logic [255:0]      pipe_digest_in,
  output logic [127:0]      pipe_block_in,
  input  logic [255:0]      pipe_digest_out,
  input  logic              pipe_valid_out,
  output logic              found_valid,
  input  logic              found_ready,
  output logic [31:0]       found_nonce,
  output logic [255:0]      found_digest,
  output logic              busy,
  output logic              done,
  output logic [LOST_W-1:0] lost_count
);
  localparam int OW = $clog2(LATENCY + 2);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state;
  logic [95:0] blk;
  logic [31:0] end_nonce, issue_nonce, result_nonce;
  logic [7:0] zero_bits;
  logic [OW-1:0] outstanding, out_next;
  logic [127:0] blk_hold;
  logic discard, issue, counted, hit, take, consume, load;
  assign issue = state == ISSUE && !abort;
  assign counted = pipe_valid_out && outstanding != '0;
  assign out_next = outstanding + OW'(issue) - OW'(counted);
  assign hit = (pipe_digest_out >> (9'd256 - {1'b0, zero_bits})) == '0;
  assign take = counted && hit && !discard && !(state == ISSUE && abort);
  assign consume = found_valid && found_ready;
  assign load = take && (!found_valid || found_ready);
  assign pipe_write_en = issue;
  assign pipe_block_in = issue ? {blk, issue_nonce} : blk_hold;
  assign busy = state != IDLE;
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      work_ready <= 1'b0;
      blk <= '0;
      end_nonce <= '0;
      issue_nonce <= '0;
      result_nonce <= '0;
      zero_bits <= '0;
      outstanding <= '0;
      blk_hold <= '0;
      discard <= 1'b0;
      pipe_digest_initial <= '0;
      pipe_digest_in <= '0;
      found_valid <= 1'b0;
      found_nonce <= '0;
      found_digest <= '0;
      done <= 1'b0;
      lost_count <= '0;
    end else begin
      outstanding <= out_next;
      done <= 1'b0;
      if (issue) begin
        blk_hold <= pipe_block_in;
        issue_nonce <= issue_nonce + 32'd1;
      end
      if (counted) result_nonce <= result_nonce + 32'd1;
      if (load) begin
        found_valid <= 1'b1;
        found_nonce <= result_nonce;
        found_digest <= pipe_digest_out;
      end else if (consume) found_valid <= 1'b0;
      if (take && !load && lost_count != '1) lost_count <= lost_count + 1'b1;
      if (state == IDLE) begin
        if (work_valid && work_ready) begin
          blk <= work_block;
          end_nonce <= work_nonce_end;
          zero_bits <= work_zero_bits;
          pipe_digest_initial <= work_digest_initial;
          pipe_digest_in <= work_digest_in;
          issue_nonce <= work_nonce_start;
          result_nonce <= work_nonce_start;
          discard <= 1'b0;
          work_ready <= 1'b0;
          state <= ISSUE;
        end else work_ready <= 1'b1;
      end else if (state == ISSUE) begin
        if (abort) begin
          discard <= 1'b1;
          state <= DRAIN;
        end else if (issue_nonce == end_nonce) state <= DRAIN;
      end else if (out_next == '0) begin
        done <= 1'b1;
        work_ready <= 1'b1;
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_sha_nonce_dispatcher.sv
// tb_sha_nonce_dispatcher: directed bench with a queue-based reference model and a delay-line pipeline stand-in
module tb_sha_nonce_dispatcher;
  localparam int LAT = 65;
  logic clk = 1'b0, rst = 1'b1;
  logic work_valid = 1'b0, work_ready, abort = 1'b0;
  logic [255:0] work_digest_initial = '0, work_digest_in = '0;
  logic [95:0] work_block = '0;
  logic [31:0] work_nonce_start = '0, work_nonce_end = '0;
  logic [7:0] work_zero_bits = '0;
  logic pipe_write_en, pipe_valid_out, found_valid, found_ready = 1'b0, busy, done;
  logic [255:0] pipe_digest_initial, pipe_digest_in, pipe_digest_out, found_digest;
  logic [127:0] pipe_block_in;
  logic [31:0] found_nonce;
  logic [7:0] lost_count;
  sha_nonce_dispatcher #(.LATENCY(LAT), .LOST_W(8)) dut (
    .CLK(clk), .RST(rst), .work_valid(work_valid), .work_ready(work_ready),
    .work_digest_initial(work_digest_initial), .work_digest_in(work_digest_in),
    .work_block(work_block), .work_nonce_start(work_nonce_start),
    .work_nonce_end(work_nonce_end), .work_zero_bits(work_zero_bits), .abort(abort),
    .pipe_write_en(pipe_write_en), .pipe_digest_initial(pipe_digest_initial),
    .pipe_digest_in(pipe_digest_in), .pipe_block_in(pipe_block_in),
    .pipe_digest_out(pipe_digest_out), .pipe_valid_out(pipe_valid_out),
    .found_valid(found_valid), .found_ready(found_ready), .found_nonce(found_nonce),
    .found_digest(found_digest), .busy(busy), .done(done), .lost_count(lost_count)
  );
  always #5 clk = ~clk;
  logic [LAT-1:0] pv = '0;
  logic [31:0] pn [LAT];
  always @(posedge clk) begin
    pv <= {pv[LAT-2:0], pipe_write_en};
    pn[0] <= pipe_block_in[31:0];
    for (int i = 1; i < LAT; i++) pn[i] <= pn[i-1];
  end
  assign pipe_valid_out = pv[LAT-1];
  assign pipe_digest_out = {224'h0, pn[LAT-1]};
  int checks = 0, fails = 0;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  function automatic int lz(input logic [255:0] d);
    for (int i = 255; i >= 0; i--) if (d[i]) return 255 - i;
    return 256;
  endfunction
  bit m_init = 0, m_ready, m_fv, m_done, m_disc, got, disc, exp_we;
  int m_st, cyc = 0, n_wr = 0, n_done = 0, wr_cyc = 0, fv_cyc = 0;
  logic [31:0] m_nonce, m_end, m_fn, rn;
  logic [7:0] m_zb, m_lost;
  logic [95:0] m_blk;
  logic [127:0] m_hold, exp_blk;
  logic [255:0] m_fd, m_di, m_dn;
  logic [31:0] m_q[$], found_q[$];
  logic [255:0] fd_q[$];
  logic prev_fv = 1'b0;
  always @(negedge clk) begin
    cyc++;
    exp_we = m_init && m_st == 1 && !abort;
    exp_blk = exp_we ? {m_blk, m_nonce} : m_hold;
    if (m_init) begin
      chk("pipe_write_en", pipe_write_en, exp_we);
      chk("pipe_block_in", pipe_block_in, exp_blk);
      chk("pipe_digest_initial", pipe_digest_initial, m_di);
      chk("pipe_digest_in", pipe_digest_in, m_dn);
      chk("found_valid", found_valid, m_fv);
      chk("found_nonce", found_nonce, m_fn);
      chk("found_digest", found_digest, m_fd);
      chk("done", done, m_done);
      chk("busy", busy, m_st != 0);
      chk("work_ready", work_ready, m_ready);
      chk("lost_count", lost_count, m_lost);
    end
    if (pipe_write_en === 1'b1) begin n_wr++; wr_cyc = cyc; end
    if (found_valid === 1'b1 && !prev_fv) fv_cyc = cyc;
    prev_fv = found_valid === 1'b1;
    if (found_valid === 1'b1 && found_ready) begin
      found_q.push_back(found_nonce);
      fd_q.push_back(found_digest);
    end
    if (done === 1'b1) n_done++;
    if (rst) begin
      m_init = 1; m_st = 0; m_ready = 0; m_q.delete(); m_hold = '0; m_fv = 0; m_fn = '0;
      m_fd = '0; m_lost = '0; m_done = 0; m_disc = 0; m_blk = '0; m_nonce = '0; m_end = '0;
      m_zb = '0; m_di = '0; m_dn = '0;
    end else if (m_init) begin
      disc = m_disc || (m_st == 1 && abort);
      got = 0;
      if (pipe_valid_out && m_q.size() > 0) begin rn = m_q.pop_front(); got = 1; end
      if (got && lz(pipe_digest_out) >= int'(m_zb) && !disc) begin
        if (!m_fv || found_ready) begin m_fv = 1; m_fn = rn; m_fd = pipe_digest_out; end
        else if (m_lost != 8'hff) m_lost++;
      end else if (m_fv && found_ready) m_fv = 0;
      if (exp_we) begin m_q.push_back(m_nonce); m_hold = exp_blk; end
      m_done = 0;
      if (m_st == 0) begin
        if (m_ready && work_valid) begin
          m_blk = work_block; m_nonce = work_nonce_start; m_end = work_nonce_end;
          m_zb = work_zero_bits; m_di = work_digest_initial; m_dn = work_digest_in;
          m_disc = 0; m_st = 1;
        end
      end else if (m_st == 1) begin
        if (abort) begin m_st = 2; m_disc = 1; end
        else begin
          if (m_nonce == m_end) m_st = 2;
          m_nonce++;
        end
      end else if (m_q.size() == 0) begin m_done = 1; m_st = 0; end
      m_ready = m_st == 0;
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; abort = 1'b0; found_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic start_work(input logic [31:0] s, input logic [31:0] e, input logic [7:0] z);
    int k = 0;
    while (work_ready !== 1'b1 && k < 20) begin tick(); k++; end
    if (k == 20) chk("work_ready_timeout", 1'b0, 1'b1);
    work_nonce_start = s; work_nonce_end = e; work_zero_bits = z;
    work_block = {$urandom, $urandom, $urandom};
    work_digest_initial = {8{$urandom}};
    work_digest_in = {8{$urandom}};
    work_valid = 1'b1;
    tick();
    work_valid = 1'b0;
  endtask
  task automatic wait_done(input int limit);
    int k = 0;
    while (done !== 1'b1 && k < limit) begin tick(); k++; end
    if (k == limit) chk("done_timeout", 1'b0, 1'b1);
    repeat (3) tick();
  endtask
  task automatic chk_found(input string nm, input int base, input logic [31:0] exp[]);
    chk({nm, "_count"}, 256'(found_q.size() - base), 256'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk(nm, (base + i < found_q.size()) ? found_q[base + i] : 32'hxxxxxxxx, exp[i]);
  endtask
  int w0, f0, d0;
  initial begin
    do_reset();
    chk("reset_work_ready", work_ready, 1'b1);
    chk("reset_lost", lost_count, 8'd0);
    found_ready = 1'b1; w0 = n_wr; f0 = found_q.size(); d0 = n_done;
    start_work(32'h5, 32'h5, 8'd0);
    wait_done(200);
    chk("t1_writes", 256'(n_wr - w0), 256'd1);
    chk_found("t1_nonce", f0, '{32'h5});
    chk("t1_digest", (f0 < fd_q.size()) ? fd_q[f0] : 'x, 256'h5);
    chk("t1_latency", 256'(fv_cyc - wr_cyc), 256'(LAT + 1));
    chk("t1_done", 256'(n_done - d0), 256'd1);
    chk("t1_ready", work_ready, 1'b1);
    do_reset();
    found_ready = 1'b1; w0 = n_wr; f0 = found_q.size();
    start_work(32'h0, 32'h9, 8'd252);
    wait_done(200);
    chk("t2_writes", 256'(n_wr - w0), 256'd10);
    chk_found("t2_nonce", f0, '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9});
    chk("t2_lost", lost_count, 8'd0);
    do_reset();
    found_ready = 1'b1; f0 = found_q.size(); d0 = n_done;
    start_work(32'h0, 32'h9, 8'd254);
    wait_done(200);
    chk_found("t3_nonce", f0, '{0, 1, 2, 3});
    chk("t3_done", 256'(n_done - d0), 256'd1);
    do_reset();
    found_ready = 1'b0; f0 = found_q.size();
    start_work(32'h0, 32'h3, 8'd0);
    wait_done(200);
    chk("t4_valid_held", found_valid, 1'b1);
    chk("t4_nonce_held", found_nonce, 32'h0);
    chk("t4_lost", lost_count, 8'd3);
    found_ready = 1'b1;
    tick();
    chk("t4_valid_drop", found_valid, 1'b0);
    chk_found("t4_nonce", f0, '{32'h0});
    do_reset();
    found_ready = 1'b1; w0 = n_wr; f0 = found_q.size();
    start_work(32'hffff_fffe, 32'h1, 8'd0);
    wait_done(200);
    chk("t5_writes", 256'(n_wr - w0), 256'd4);
    chk_found("t5_nonce", f0, '{32'hffff_fffe, 32'hffff_ffff, 32'h0, 32'h1});
    do_reset();
    found_ready = 1'b1; w0 = n_wr; f0 = found_q.size(); d0 = n_done;
    start_work(32'h0, 32'd99, 8'd0);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(200);
    chk("t6_writes", 256'(n_wr - w0), 256'd2);
    chk("t6_found", 256'(found_q.size() - f0), 256'd0);
    chk("t6_done", 256'(n_done - d0), 256'd1);
    do_reset();
    found_ready = 1'b1; f0 = found_q.size(); d0 = n_done;
    start_work(32'h0, 32'd99, 8'd0);
    repeat (9) tick();
    chk("t7_issuing", pipe_write_en, 1'b1);
    rst = 1'b1;
    tick();
    chk("t7_write_off", pipe_write_en, 1'b0);
    rst = 1'b0;
    repeat (80) tick();
    chk("t7_found", 256'(found_q.size() - f0), 256'd0);
    chk("t7_done", 256'(n_done - d0), 256'd0);
    chk("t7_ready", work_ready, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/sha_nonce_dispatcher.md
Name: sha_nonce_dispatcher

Overview:
- Drives the unrolled SHA-256 pipeline from the work side and collects its results.
- Accepts one work unit: initial digest, mid-state, 96-bit block tail, nonce range and difficulty. Streams one nonce per cycle into the pipeline.
- Matches in-order pipeline results back to their nonces and checks each digest against a leading-zero target. Reports hits over a valid/ready handshake.

Parameters:
LATENCY, 65, cycles from pipe_write_en to the matching pipe_valid_out (informational; sizes the outstanding counter)
LOST_W, 8, width of the saturating dropped-hit counter

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
work_valid  in  1  work unit offered
work_ready  out  1  dispatcher idle, accepts work
work_digest_initial  in  256  final-add digest for pipeline
work_digest_in  in  256  pre-advanced mid-state
work_block  in  96  block_in bits above the nonce
work_nonce_start  in  32  first nonce
work_nonce_end  in  32  last nonce (inclusive)
work_zero_bits  in  8  required leading zero bits of digest (0..255)
abort  in  1  stop issuing, flush
pipe_write_en  out  1  issue strobe to pipeline
pipe_digest_initial  out  256  to pipeline digest_intial
pipe_digest_in  out  256  to pipeline digest_in
pipe_block_in  out  128  {block[95:0], nonce[31:0]}
pipe_digest_out  in  256  pipeline result
pipe_valid_out  in  1  pipeline result valid
found_valid  out  1  hit available
found_ready  in  1  hit consumed
found_nonce  out  32  nonce of hit
found_digest  out  256  digest of hit
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, work unit complete
lost_count  out  LOST_W  saturating count of dropped hits

Behaviour:
- Reset (RST high at a CLK edge):
  - state=IDLE; outstanding=0.
  - All outputs 0, except work_ready=1 from the first cycle after RST deasserts.
  - lost_count clears only on reset.
- IDLE:
  - work_ready=1.
  - On work_valid, latch all work_* fields; issue_nonce=result_nonce=work_nonce_start; go ISSUE next cycle.
  - work_ready is registered and drops in the cycle after acceptance.
- ISSUE:
  - Every cycle: pipe_write_en=1, pipe_block_in={work_block, issue_nonce}; issue_nonce+1 (wraps FFFFFFFF->0).
  - After issuing the cycle where issue_nonce==work_nonce_end, go DRAIN.
  - start==end issues exactly one nonce. start=0, end=FFFFFFFF issues all 2^32 nonces.
  - pipe_digest_initial and pipe_digest_in hold the latched values throughout. pipe_block_in holds its last value when pipe_write_en=0.
- abort:
  - abort high in an ISSUE cycle: that cycle does not issue; go DRAIN.
  - Hits arriving after abort are discarded.
  - abort in IDLE or DRAIN has no effect on state.
- outstanding counter, width clog2(LATENCY+2):
  - +1 on issue, -1 on pipe_valid_out; simultaneous issue and valid leave it unchanged.
  - pipe_valid_out with outstanding==0 is ignored entirely (stale results after reset).
- Result path, on each counted pipe_valid_out:
  - hit = (pipe_digest_out >> (256-work_zero_bits)) == 0; work_zero_bits=0 is always a hit.
  - The result's nonce is result_nonce; result_nonce then increments (wraps).
  - Pipeline is in-order; no nonce FIFO.
- Found register (one entry):
  - A hit loads found_nonce/found_digest and sets found_valid the next cycle.
  - found_valid and data hold until found_valid && found_ready.
  - A hit arriving while the register is full and not being consumed that cycle is dropped; lost_count+1, saturating at all-ones.
  - A hit arriving in the same cycle as consumption is loaded (no drop).
- DRAIN:
  - When outstanding==0 (including any same-cycle decrement already applied), pulse done=1 for one cycle and return to IDLE.
  - An unconsumed found entry persists into IDLE.
- busy=1 in ISSUE and DRAIN.
- Reset mid-operation: abandons the work unit; no done pulse.

Test Plan:
Bench pipeline model: LATENCY-cycle delay line, digest_out={224'h0, block_in[31:0]}, valid_out=delayed write_en.

1. start=end=00000005, zero_bits=0, found_ready=1 -> exactly 1 pipe_write_en cycle with pipe_block_in[31:0]=5; found_valid with found_nonce=5, found_digest=256'h5 at LATENCY+1 cycles after issue; done pulses once; work_ready=1 after.
2. start=0, end=9, zero_bits=252, found_ready=1 -> 10 consecutive writes; 10 hits with nonces 0..9 in order; lost_count=0.
3. start=0, end=9, zero_bits=254 -> hits only for nonces 0..3; found_nonce sequence 0,1,2,3; done after the 10th result.
4. start=0, end=3, zero_bits=0, found_ready=0 -> found_nonce=0 held; lost_count=3; raising found_ready afterwards drops found_valid next cycle.
5. start=FFFFFFFE, end=00000001 -> 4 writes, nonces FFFFFFFE, FFFFFFFF, 0, 1; found nonces match in order.
6. start=0, end=99; abort high in 3rd ISSUE cycle -> exactly 2 writes; no found_valid; done after 2 results.
7. start=0, end=99; RST in 10th ISSUE cycle -> pipe_write_en=0 next cycle; stale valid_outs produce no found_valid and no done; work_ready=1 after reset.
